wallace_mac_pipe: RTL and testbench

- Parametrised, 3-stage pipelined multiply-accumulate built around a Wallace-tree reduction; successor to the fixed 8x8 combinational multiplier in the mac area.
- Adds selectable signed/unsigned operands, an accumulator with clear, and valid/ready flow control with full backpressure.
- Sits between the operand fetch logic and the MAC result consumer.

---
 rtl/mac_pkg.sv | 28 ++
 rtl/wallace_mac_pipe_reduce.sv | 43 ++++
 rtl/wallace_mac_pipe.sv | 82 ++++++++
 tb/tb_wallace_mac_pipe.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// mac_pkg: shared constants, control bundle and tree-sizing helpers for the MAC pipeline
package mac_pkg;
  localparam int PIPE_DEPTH = 3;
  typedef struct packed {
    logic valid;
    logic signed_mode;
    logic acc_en;
    logic acc_clr;
  } ctrl_t;
  function automatic int acc_w_default(input int w);
    return 2 * w + 8;
  endfunction
  function automatic logic [63:0] bw_const(input int w);
    return (64'd1 << w) | (64'd1 << (2 * w - 1));
  endfunction
  function automatic int wt_rows(input int n, input int l);
    for (int i = 0; i < l; i++) n = n - n / 3;
    return n;
  endfunction
  function automatic int wt_levels(input int n);
    int l = 0;
    while (n > 2) begin
      n = n - n / 3;
      l++;
    end
    return l;
  endfunction
endpackage

// File: rtl/wallace_mac_pipe_reduce.sv
// wallace_reduce: combinational Wallace tree of full-adder rows reducing the partial products plus Baugh-Wooley correction to two rows
module wallace_reduce
  import mac_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0][W-1:0] pp,
  input  logic                signed_mode,
  output logic [2*W-1:0]      row0,
  output logic [2*W-1:0]      row1
);
  localparam int P = 2 * W;
  localparam int N = W + 1;
  localparam int L = wt_levels(N);
  localparam logic [P-1:0] BW = P'(bw_const(W));
  logic [P-1:0] lv [0:L][0:N-1];
  genvar i, l, j;
  for (i = 0; i < W; i++) begin : g_pp
    assign lv[0][i] = {{W{1'b0}}, pp[i]} << i;
  end
  assign lv[0][W] = signed_mode ? BW : '0;
  for (l = 0; l < L; l++) begin : g_lvl
    localparam int NI = wt_rows(N, l);
    localparam int G = NI / 3;
    localparam int NO = NI - G;
    for (j = 0; j < N; j++) begin : g_row
      localparam int K = 3 * (j / 2);
      if (j < 2 * G) begin : g_fa
        if (j % 2 == 0) begin : g_s
          assign lv[l+1][j] = lv[l][K] ^ lv[l][K+1] ^ lv[l][K+2];
        end else begin : g_c
          assign lv[l+1][j] = ((lv[l][K] & lv[l][K+1]) | (lv[l][K] & lv[l][K+2]) | (lv[l][K+1] & lv[l][K+2])) << 1;
        end
      end else if (j < NO) begin : g_pass
        assign lv[l+1][j] = lv[l][j+G];
      end else begin : g_zero
        assign lv[l+1][j] = '0;
      end
    end
  end
  assign row0 = lv[L][0];
  assign row1 = lv[L][1];
endmodule

// File: rtl/wallace_mac_pipe.sv
// wallace_mac_pipe: 3-stage Wallace-tree multiply-accumulate with valid/ready backpressure; MAC_SAT_EN selects saturating accumulate and adds sat_flag
module wallace_mac_pipe
  import mac_pkg::*;
#(
  parameter int W     = 8,
  parameter int ACC_W = acc_w_default(W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic             signed_mode,
  input  logic             acc_en,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef MAC_SAT_EN
  output logic             sat_flag,
`endif
  output logic [ACC_W-1:0] result
);
  logic [W-1:0][W-1:0] pp, pp1;
  logic [2*W-1:0] r0, r1, s0, s1, prod;
  logic [ACC_W-1:0] acc, ext, base, sum, nxt;
  ctrl_t c1, c2;
  logic en, sat;
  assign in_ready = !out_valid || out_ready;
  assign en = in_ready;
  always_comb
    for (int i = 0; i < W; i++)
      for (int j = 0; j < W; j++)
        pp[i][j] = (a[j] & b[i]) ^ (signed_mode & ((i == W - 1) != (j == W - 1)));
  wallace_reduce #(.W(W)) u_reduce (
    .pp         (pp1),
    .signed_mode(c1.signed_mode),
    .row0       (r0),
    .row1       (r1)
  );
  assign prod = s0 + s1;
  assign ext = c2.signed_mode ? ACC_W'($signed(prod)) : ACC_W'(prod);
  assign base = c2.acc_clr ? '0 : acc;
`ifdef MAC_SAT_EN
  logic cy, sovf;
  assign {cy, sum} = {1'b0, base} + {1'b0, ext};
  assign sovf = (base[ACC_W-1] == ext[ACC_W-1]) && (sum[ACC_W-1] != base[ACC_W-1]);
  always_comb begin
    sat = c2.acc_en && (c2.signed_mode ? sovf : cy);
    nxt = !sat ? sum : !c2.signed_mode ? '1 : ext[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
  end
`else
  assign sum = base + ext;
  assign sat = 1'b0;
  assign nxt = sum;
`endif
  always_ff @(posedge clk)
    if (rst) begin
      c1 <= '0;
      c2 <= '0;
      out_valid <= 1'b0;
      result <= '0;
      acc <= '0;
`ifdef MAC_SAT_EN
      sat_flag <= 1'b0;
`endif
    end else if (en) begin
      c1 <= {in_valid, signed_mode, acc_en, acc_clr};
      pp1 <= pp;
      c2 <= c1;
      s0 <= r0;
      s1 <= r1;
      out_valid <= c2.valid;
      if (c2.valid) begin
        result <= c2.acc_en ? nxt : ext;
        acc <= c2.acc_en ? nxt : c2.acc_clr ? '0 : acc;
`ifdef MAC_SAT_EN
        sat_flag <= sat;
`endif
      end
    end
endmodule

// File: tb/tb_wallace_mac_pipe.sv
// tb_wallace_mac_pipe: directed self-checking bench for the Wallace-tree MAC pipeline
module tb_wallace_mac_pipe;
  import mac_pkg::*;
  localparam int W = 8;
  localparam int AW = 16;
  logic clk = 1'b0;
  logic rst, in_valid, in_ready, signed_mode, acc_en, acc_clr, out_valid, out_ready;
  logic [W-1:0] a, b;
  logic [AW-1:0] result;
`ifdef MAC_SAT_EN
  logic sat_flag;
`endif
  int n_cmp = 0;
  int n_bad = 0;
  always #5 clk = ~clk;
  wallace_mac_pipe #(.W(W), .ACC_W(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .signed_mode(signed_mode),
    .acc_en     (acc_en),
    .acc_clr    (acc_clr),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
`ifdef MAC_SAT_EN
    .sat_flag   (sat_flag),
`endif
    .result     (result)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic beat(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sm, input logic ae, input logic ac);
    a = av;
    b = bv;
    signed_mode = sm;
    acc_en = ae;
    acc_clr = ac;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask
  task automatic get(input string tag, input logic [AW-1:0] exp, input int lat);
    int n = 1;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1 n++;
    end
    chk({tag, " valid"}, out_valid, 1);
    chk(tag, result, exp);
    if (lat > 0) chk({tag, " latency"}, n, lat);
    @(posedge clk);
    #1;
  endtask
  initial begin
    int k, got, cyc;
    logic take, give, seen;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    a = '0;
    b = '0;
    signed_mode = 1'b0;
    acc_en = 1'b0;
    acc_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst out_valid", out_valid, 0);
    chk("rst result", result, 0);
    chk("rst in_ready", in_ready, 1);
`ifdef MAC_SAT_EN
    chk("rst sat_flag", sat_flag, 0);
`endif
    beat(8'hFF, 8'hFF, 0, 0, 0);
    get("u 255*255", 16'hFE01, PIPE_DEPTH);
    beat(8'h00, 8'hFF, 0, 0, 0);
    get("u 0*255", 16'h0000, 0);
    beat(8'h80, 8'h80, 1, 0, 0);
    get("s -128*-128", 16'h4000, PIPE_DEPTH);
    beat(8'h80, 8'h7F, 1, 0, 0);
    get("s -128*127", 16'hC080, 0);
    beat(8'hFF, 8'hFF, 1, 0, 0);
    get("s -1*-1", 16'h0001, 0);
    beat(8'h00, 8'h80, 1, 0, 0);
    get("s 0*-128", 16'h0000, 0);
    beat(8'hFF, 8'hFF, 1, 0, 0);
    beat(8'hFF, 8'hFF, 0, 0, 0);
    get("mixed s", 16'h0001, 0);
    get("mixed u", 16'hFE01, 0);
    beat(8'd3, 8'd4, 0, 1, 1);
    get("acc 12", 16'd12, 0);
    beat(8'd5, 8'd6, 0, 1, 0);
    get("acc 42", 16'd42, 0);
    beat(8'd7, 8'd8, 0, 1, 0);
    get("acc 98", 16'd98, 0);
    beat(8'd2, 8'd2, 0, 1, 1);
    get("acc clr 4", 16'd4, 0);
    beat(8'd3, 8'd3, 0, 0, 1);
    get("clr noacc", 16'd9, 0);
    beat(8'd1, 8'd1, 0, 1, 0);
    get("acc after clr", 16'd1, 0);
    k = 1;
    got = 0;
    cyc = 0;
    acc_en = 1'b0;
    acc_clr = 1'b0;
    signed_mode = 1'b0;
    while (got < 6 && cyc < 60) begin
      out_ready = !(cyc >= 3 && cyc <= 6);
      in_valid = (k <= 6);
      a = W'(k);
      b = 8'd10;
      #1;
      take = in_valid && in_ready;
      give = out_valid && out_ready;
      if (give) begin
        chk("stream result", result, 64'(10 * (got + 1)));
        got++;
      end
      if (out_valid && !out_ready) begin
        chk("stall in_ready", in_ready, 0);
        chk("stall hold", result, 64'(10 * (got + 1)));
      end
      @(posedge clk);
      #1 cyc++;
      if (take) k++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("stream count", got, 6);
    repeat (3) @(posedge clk);
    #1 chk("stream no extra", out_valid, 0);
    beat(8'd9, 8'd9, 0, 1, 0);
    beat(8'd9, 8'd9, 0, 1, 0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      seen |= out_valid;
      @(posedge clk);
      #1;
    end
    chk("rst drops beats", seen, 0);
    beat(8'd5, 8'd5, 0, 1, 0);
    get("acc after rst", 16'd25, 0);
    beat(8'd127, 8'd127, 1, 1, 1);
    get("sat acc1", 16'd16129, 0);
`ifdef MAC_SAT_EN
    chk("sat_flag 1", sat_flag, 0);
`endif
    beat(8'd127, 8'd127, 1, 1, 0);
    get("sat acc2", 16'd32258, 0);
`ifdef MAC_SAT_EN
    chk("sat_flag 2", sat_flag, 0);
    beat(8'd127, 8'd127, 1, 1, 0);
    get("sat acc3", 16'h7FFF, 0);
    chk("sat_flag 3", sat_flag, 1);
`else
    beat(8'd127, 8'd127, 1, 1, 0);
    get("wrap acc3", 16'hBD03, 0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
